// File: rtl/aes_io_pkg.sv
// Shared constants, host command encodings and controller state type for aes_io_ctrl.
package aes_io_pkg;

    localparam int unsigned NBYTES = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BLK_W  = NBYTES * BYTE_W;
    localparam int unsigned CNT_W  = $clog2(NBYTES);
    localparam int unsigned CMD_W  = 2;

    localparam logic [CMD_W-1:0] CMD_NOP       = 2'b00;
    localparam logic [CMD_W-1:0] CMD_LOAD_KEY  = 2'b01;
    localparam logic [CMD_W-1:0] CMD_LOAD_DATA = 2'b10;
    localparam logic [CMD_W-1:0] CMD_READ_OUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_DATA = 2'd2,
        ST_BUSY = 2'd3
    } state_e;

endpackage : aes_io_pkg

// File: rtl/aes_byte_shreg.sv
// 16x8 shift-in / parallel-out byte register. The first byte shifted in ends up
// in the most significant byte once all 16 bytes have arrived. A clear together
// with an enable restarts the register with the incoming byte as byte 0.
module aes_byte_shreg
    import aes_io_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] din_i,
    output logic [BLK_W-1:0]  data_o
);

    logic [BLK_W-1:0] data_q;
    logic [BLK_W-1:0] data_d;

    // Next value: restart, shift one byte in at the bottom, or hold.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = en_i ? BLK_W'(din_i) : '0;
        end else if (en_i) begin
            data_d = {data_q[BLK_W-BYTE_W-1:0], din_i};
        end
    end

    // Byte storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : aes_byte_shreg

// File: rtl/aes_io_ctrl.sv
// Byte-serial host interface for the AES core: assembles key and data blocks from
// DIN under CMD, launches the core, and streams the result back out on DOUT.
// Optional build macro AES_IO_WATCHDOG_EN adds a BUSY timeout that aborts the core.
module aes_io_ctrl
    import aes_io_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_,
    input  logic [CMD_W-1:0]  CMD,
    input  logic [BYTE_W-1:0] DIN,
    output logic              READY,
    output logic              OK,
    output logic [BYTE_W-1:0] DOUT,
    output logic [BLK_W-1:0]  key,
    output logic              key_load,
    output logic [BLK_W-1:0]  blk_in,
    output logic              start,
    input  logic              core_done,
    input  logic [BLK_W-1:0]  blk_out,
    output logic              core_abort
);

`ifdef AES_IO_WATCHDOG_EN
    localparam int unsigned WDOG_CYC = 255;
    localparam int unsigned WDOG_W   = $clog2(WDOG_CYC + 1);
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              key_valid_q, key_valid_d;
    logic              ready_q, ready_d;
    logic              ok_q, ok_d;
    logic [BYTE_W-1:0] dout_q, dout_d;
    logic [BLK_W-1:0]  key_q, key_d;
    logic              key_load_q, key_load_d;
    logic [BLK_W-1:0]  blk_in_q, blk_in_d;
    logic              start_q, start_d;
    logic [BLK_W-1:0]  out_buf_q, out_buf_d;
`ifdef AES_IO_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              core_abort_q, core_abort_d;
`endif

    logic              key_clr_c, key_en_c;
    logic              dat_clr_c, dat_en_c;
    logic [BLK_W-1:0]  key_sr_c, dat_sr_c;
    logic [BLK_W-1:0]  key_asm_c, dat_asm_c;
    logic              last_c;
    logic              unused_sr_c;

    // Partial key assembly.
    aes_byte_shreg u_key_sr (
        .clk_i  (CLK),
        .rst_ni (RST_),
        .clr_i  (key_clr_c),
        .en_i   (key_en_c),
        .din_i  (DIN),
        .data_o (key_sr_c)
    );

    // Partial data block assembly.
    aes_byte_shreg u_dat_sr (
        .clk_i  (CLK),
        .rst_ni (RST_),
        .clr_i  (dat_clr_c),
        .en_i   (dat_en_c),
        .din_i  (DIN),
        .data_o (dat_sr_c)
    );

    // The 16th byte is merged straight from DIN so the full block lands in one edge;
    // the oldest byte of the shift registers is therefore never needed here.
    assign key_asm_c   = {key_sr_c[BLK_W-BYTE_W-1:0], DIN};
    assign dat_asm_c   = {dat_sr_c[BLK_W-BYTE_W-1:0], DIN};
    assign unused_sr_c = ^{key_sr_c[BLK_W-1:BLK_W-BYTE_W], dat_sr_c[BLK_W-1:BLK_W-BYTE_W]};
    assign last_c      = (cnt_q == CNT_W'(NBYTES - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_cnt_d    = rd_cnt_q;
        key_valid_d = key_valid_q;
        ok_d        = ok_q;
        dout_d      = dout_q;
        key_d       = key_q;
        blk_in_d    = blk_in_q;
        out_buf_d   = out_buf_q;
        key_load_d  = 1'b0;
        start_d     = 1'b0;
        key_clr_c   = 1'b0;
        key_en_c    = 1'b0;
        dat_clr_c   = 1'b0;
        dat_en_c    = 1'b0;
`ifdef AES_IO_WATCHDOG_EN
        wdog_d       = '0;
        core_abort_d = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                unique case (CMD)
                    CMD_LOAD_KEY: begin
                        key_clr_c = 1'b1;
                        key_en_c  = 1'b1;
                        cnt_d     = CNT_W'(1);
                        state_d   = ST_KEY;
                    end
                    CMD_LOAD_DATA: begin
                        dat_clr_c = 1'b1;
                        dat_en_c  = 1'b1;
                        cnt_d     = CNT_W'(1);
                        ok_d      = 1'b0;
                        state_d   = ST_DATA;
                    end
                    CMD_READ_OUT: begin
                        if (ok_q) begin
                            dout_d = out_buf_q[BLK_W - 1 - (32'(rd_cnt_q) * BYTE_W) -: BYTE_W];
                            if (rd_cnt_q == CNT_W'(NBYTES - 1)) begin
                                rd_cnt_d = '0;
                                ok_d     = 1'b0;
                            end else begin
                                rd_cnt_d = rd_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end

            ST_KEY: begin
                if (CMD == CMD_LOAD_KEY) begin
                    if (last_c) begin
                        key_d       = key_asm_c;
                        key_load_d  = 1'b1;
                        key_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        key_en_c = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end else if (CMD != CMD_NOP) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_DATA: begin
                if (CMD == CMD_LOAD_DATA) begin
                    if (last_c) begin
                        cnt_d = '0;
                        if (key_valid_q) begin
                            blk_in_d = dat_asm_c;
                            start_d  = 1'b1;
                            state_d  = ST_BUSY;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        dat_en_c = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end else if (CMD != CMD_NOP) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_BUSY: begin
                if (core_done) begin
                    out_buf_d = blk_out;
                    ok_d      = 1'b1;
                    rd_cnt_d  = '0;
                    state_d   = ST_IDLE;
`ifdef AES_IO_WATCHDOG_EN
                end else if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
                    core_abort_d = 1'b1;
                    ok_d         = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
`endif
                end
            end

            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d != ST_BUSY);
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            key_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            ok_q        <= 1'b0;
            dout_q      <= '0;
            key_q       <= '0;
            key_load_q  <= 1'b0;
            blk_in_q    <= '0;
            start_q     <= 1'b0;
            out_buf_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            key_valid_q <= key_valid_d;
            ready_q     <= ready_d;
            ok_q        <= ok_d;
            dout_q      <= dout_d;
            key_q       <= key_d;
            key_load_q  <= key_load_d;
            blk_in_q    <= blk_in_d;
            start_q     <= start_d;
            out_buf_q   <= out_buf_d;
        end
    end

`ifdef AES_IO_WATCHDOG_EN
    // BUSY timeout counter and abort pulse.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            wdog_q       <= '0;
            core_abort_q <= 1'b0;
        end else begin
            wdog_q       <= wdog_d;
            core_abort_q <= core_abort_d;
        end
    end

    assign core_abort = core_abort_q;
`else
    assign core_abort = 1'b0;
`endif

    assign READY    = ready_q;
    assign OK       = ok_q;
    assign DOUT     = dout_q;
    assign key      = key_q;
    assign key_load = key_load_q;
    assign blk_in   = blk_in_q;
    assign start    = start_q;

endmodule : aes_io_ctrl

// File: tb/tb_aes_io_ctrl.sv
// Self-checking bench for aes_io_ctrl with a behavioural AES core stand-in.
// Build with AES_IO_WATCHDOG_EN defined to also exercise the BUSY timeout.
`timescale 1ns/1ps
module tb_aes_io_ctrl;
    import aes_io_pkg::*;

    localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;

    logic         CLK;
    logic         RST_;
    logic [1:0]   CMD;
    logic [7:0]   DIN;
    logic         READY, OK, key_load, start, core_abort;
    logic [7:0]   DOUT;
    logic [127:0] key, blk_in;
    logic         core_done;
    logic [127:0] blk_out;

    int n_cmp, n_bad;
    int kl_cnt, st_cnt, ab_cnt;
    int core_cnt;
    bit core_hold;
    int late_req, late_ack;
    logic [7:0] exp_q[$];

    aes_io_ctrl dut (
        .CLK        (CLK),
        .RST_       (RST_),
        .CMD        (CMD),
        .DIN        (DIN),
        .READY      (READY),
        .OK         (OK),
        .DOUT       (DOUT),
        .key        (key),
        .key_load   (key_load),
        .blk_in     (blk_in),
        .start      (start),
        .core_done  (core_done),
        .blk_out    (blk_out),
        .core_abort (core_abort)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One host cycle: drive at negedge, sample just after the active edge.
    task automatic step(input logic [1:0] c, input logic [7:0] d);
        @(negedge CLK);
        CMD = c;
        DIN = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_ = 1'b0;
        CMD  = CMD_NOP;
        DIN  = 8'h00;
        @(negedge CLK);
        @(negedge CLK);
        RST_ = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_state();
        check_eq("rst_ready", 128'(READY), 128'(1));
        check_eq("rst_ok", 128'(OK), 128'(0));
        check_eq("rst_dout", 128'(DOUT), 128'(0));
        check_eq("rst_start", 128'(start), 128'(0));
        check_eq("rst_key_load", 128'(key_load), 128'(0));
        check_eq("rst_key", key, 128'(0));
        check_eq("rst_blk_in", blk_in, 128'(0));
        check_eq("rst_core_abort", 128'(core_abort), 128'(0));
    endtask

    task automatic load_block(input logic [1:0] c, input logic [127:0] blk);
        for (int i = 0; i < 16; i++) step(c, 8'(blk >> (8 * (15 - i))));
    endtask

    // Issue one READ_OUT; expected byte goes into the scoreboard, DOUT is checked one edge later.
    task automatic read_byte(input logic [127:0] blk, input int idx);
        logic [7:0] e;
        exp_q.push_back(8'(blk >> (8 * (15 - idx))));
        step(CMD_READ_OUT, 8'h00);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 128'(1), 128'(0));
        end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("dout_byte%0d", idx), 128'(DOUT), 128'(e));
        end
    endtask

    // Wait in NOP for OK, counting BUSY (READY low) cycles after the start sample.
    task automatic wait_result(output int busy, output bit seen);
        busy = READY ? 0 : 1;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            step(CMD_NOP, 8'h00);
            if (OK) begin
                seen = 1'b1;
                break;
            end
            if (!READY) busy++;
        end
    endtask

    // Pulse monitor, sampled mid-cycle.
    initial begin
        kl_cnt = 0;
        st_cnt = 0;
        ab_cnt = 0;
        forever begin
            @(negedge CLK);
            if (key_load === 1'b1) kl_cnt++;
            if (start === 1'b1) st_cnt++;
            if (core_abort === 1'b1) ab_cnt++;
        end
    end

    // AES core stand-in: answers 11 cycles after start unless held off.
    initial begin
        core_done = 1'b0;
        blk_out   = '0;
        core_cnt  = 0;
        late_ack  = 0;
        forever begin
            @(posedge CLK);
            #1;
            core_done = 1'b0;
            if (late_ack != late_req) begin
                late_ack  = late_req;
                core_done = 1'b1;
                blk_out   = '1;
            end else if (core_cnt != 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_done = 1'b1;
                    blk_out   = (blk_in == PT && key == FKEY) ? CT : (blk_in ^ key);
                end
            end else if (start === 1'b1 && !core_hold) begin
                core_cnt = 10;
            end
        end
    end

    initial begin
        int  busy;
        bit  seen;
        n_cmp     = 0;
        n_bad     = 0;
        core_hold = 1'b0;
        late_req  = 0;
        RST_      = 1'b0;
        CMD       = CMD_NOP;
        DIN       = 8'h00;
        do_reset();

        // Reset state
        check_reset_state();

        // FIPS-197 key and block
        load_block(CMD_LOAD_KEY, FKEY);
        check_eq("key_load_pulse", 128'(key_load), 128'(1));
        check_eq("key_value", key, FKEY);
        check_eq("ready_after_key", 128'(READY), 128'(1));
        step(CMD_NOP, 8'h00);
        check_eq("key_load_low", 128'(key_load), 128'(0));
        check_eq("key_load_count", 128'(kl_cnt), 128'(1));

        load_block(CMD_LOAD_DATA, PT);
        check_eq("start_pulse", 128'(start), 128'(1));
        check_eq("blk_in_value", blk_in, PT);
        check_eq("busy_not_ready", 128'(READY), 128'(0));
        wait_result(busy, seen);
        check_eq("ok_seen", 128'(seen), 128'(1));
        check_eq("busy_cycles", 128'(busy), 128'(11));
        check_eq("ready_after_done", 128'(READY), 128'(1));
        check_eq("start_count", 128'(st_cnt), 128'(1));
        for (int i = 0; i < 16; i++) begin
            read_byte(CT, i);
            if (i < 15) check_eq("ok_during_read", 128'(OK), 128'(1));
        end
        check_eq("ok_after_16_reads", 128'(OK), 128'(0));
        step(CMD_READ_OUT, 8'h00);
        check_eq("dout_hold_no_ok", 128'(DOUT), 128'(8'h5a));

        // Key load with NOP stall in the middle
        for (int i = 0; i < 5; i++) step(CMD_LOAD_KEY, 8'(8'ha0 + i));
        for (int i = 0; i < 3; i++) step(CMD_NOP, 8'hee);
        for (int i = 5; i < 16; i++) step(CMD_LOAD_KEY, 8'(8'ha0 + i));
        check_eq("key_stall_value", key, KEY2);
        step(CMD_NOP, 8'h00);
        check_eq("key_load_count2", 128'(kl_cnt), 128'(2));

        // Second encryption, partial read, then a new data load drops the unread result
        load_block(CMD_LOAD_DATA, PT);
        wait_result(busy, seen);
        check_eq("ok_seen2", 128'(seen), 128'(1));
        for (int i = 0; i < 4; i++) read_byte(PT ^ KEY2, i);
        check_eq("ok_partial_read", 128'(OK), 128'(1));
        step(CMD_LOAD_DATA, 8'h55);
        check_eq("ok_cleared_by_load", 128'(OK), 128'(0));

        // Abort a data load with LOAD_KEY after 7 bytes
        for (int i = 1; i < 7; i++) step(CMD_LOAD_DATA, 8'(8'h55 + i));
        step(CMD_LOAD_KEY, 8'h77);
        check_eq("abort_ready", 128'(READY), 128'(1));
        check_eq("abort_blk_in_kept", blk_in, PT);
        step(CMD_NOP, 8'h00);
        check_eq("abort_no_start", 128'(st_cnt), 128'(2));
        check_eq("abort_key_kept", key, KEY2);
        step(CMD_READ_OUT, 8'h00);
        check_eq("abort_dout_hold", 128'(DOUT), 128'(8'h90));

        // Data block without a valid key is dropped
        do_reset();
        check_reset_state();
        load_block(CMD_LOAD_DATA, PT);
        step(CMD_NOP, 8'h00);
        check_eq("nokey_no_start", 128'(st_cnt), 128'(2));
        check_eq("nokey_ready", 128'(READY), 128'(1));
        check_eq("nokey_ok", 128'(OK), 128'(0));
        check_eq("nokey_blk_in", blk_in, 128'(0));

`ifdef AES_IO_WATCHDOG_EN
        // Core never answers: watchdog aborts after 255 BUSY cycles
        load_block(CMD_LOAD_KEY, FKEY);
        core_hold = 1'b1;
        load_block(CMD_LOAD_DATA, PT);
        busy = READY ? 0 : 1;
        seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            step(CMD_NOP, 8'h00);
            if (core_abort) begin
                seen = 1'b1;
                break;
            end
            if (!READY) busy++;
        end
        check_eq("wdog_abort_seen", 128'(seen), 128'(1));
        check_eq("wdog_busy_cycles", 128'(busy), 128'(255));
        check_eq("wdog_ready", 128'(READY), 128'(1));
        check_eq("wdog_ok", 128'(OK), 128'(0));
        step(CMD_NOP, 8'h00);
        check_eq("wdog_abort_single", 128'(core_abort), 128'(0));
        late_req = late_req + 1;
        for (int i = 0; i < 3; i++) step(CMD_NOP, 8'h00);
        check_eq("wdog_late_done_ok", 128'(OK), 128'(0));
        check_eq("wdog_late_done_ready", 128'(READY), 128'(1));
        check_eq("wdog_abort_count", 128'(ab_cnt), 128'(1));
        core_hold = 1'b0;
`else
        check_eq("no_wdog_abort", 128'(ab_cnt), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_aes_io_ctrl
